// File: rtl/reservation_station_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : reservation_station_bank_if
// Desc    : Dispatch, CDB and per-class issue bundle for the RS bank.
//           FLUSH is present only when RS_FLUSH_EN is defined.
// Rev     : 1.0
// ============================================================================
interface reservation_station_bank_if #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 7,
  parameter int TAG_W  = 3
);
  logic              disp_valid;
  logic [TAG_W-1:0]  disp_rs;
  logic [OPC_W-1:0]  disp_opcode;
  logic [TAG_W-1:0]  disp_qj;
  logic [TAG_W-1:0]  disp_qk;
  logic [DATA_W-1:0] disp_vj;
  logic [DATA_W-1:0] disp_vk;
  logic [DATA_W-1:0] disp_imm;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic [5:0]        rs_busy;
  logic              disp_err;

  logic              st_valid, st_ready;
  logic [TAG_W-1:0]  st_tag;
  logic [OPC_W-1:0]  st_opc;
  logic [DATA_W-1:0] st_vj, st_vk, st_imm;

  logic              ld_valid, ld_ready;
  logic [TAG_W-1:0]  ld_tag;
  logic [OPC_W-1:0]  ld_opc;
  logic [DATA_W-1:0] ld_vj, ld_vk, ld_imm;

  logic              alu_valid, alu_ready;
  logic [TAG_W-1:0]  alu_tag;
  logic [OPC_W-1:0]  alu_opc;
  logic [DATA_W-1:0] alu_vj, alu_vk, alu_imm;

`ifdef RS_FLUSH_EN
  logic              flush;
`endif

  modport master (
`ifdef RS_FLUSH_EN
    output flush,
`endif
    output disp_valid, disp_rs, disp_opcode, disp_qj, disp_qk, disp_vj, disp_vk, disp_imm,
    output cdb_valid, cdb_tag, cdb_data,
    output st_ready, ld_ready, alu_ready,
    input  rs_busy, disp_err,
    input  st_valid, st_tag, st_opc, st_vj, st_vk, st_imm,
    input  ld_valid, ld_tag, ld_opc, ld_vj, ld_vk, ld_imm,
    input  alu_valid, alu_tag, alu_opc, alu_vj, alu_vk, alu_imm
  );

  modport slave (
`ifdef RS_FLUSH_EN
    input  flush,
`endif
    input  disp_valid, disp_rs, disp_opcode, disp_qj, disp_qk, disp_vj, disp_vk, disp_imm,
    input  cdb_valid, cdb_tag, cdb_data,
    input  st_ready, ld_ready, alu_ready,
    output rs_busy, disp_err,
    output st_valid, st_tag, st_opc, st_vj, st_vk, st_imm,
    output ld_valid, ld_tag, ld_opc, ld_vj, ld_vk, ld_imm,
    output alu_valid, alu_tag, alu_opc, alu_vj, alu_vk, alu_imm
  );
endinterface
`default_nettype wire

// File: rtl/reservation_station_bank.sv
`default_nettype none
// ============================================================================
// Module  : reservation_station_bank
// Desc    : Six-slot Tomasulo RS bank: dispatch, CDB wakeup/free, age-ordered
//           issue to store/load/ALU. RS_FLUSH_EN adds a global flush input.
// Rev     : 1.0
// ============================================================================
module reservation_station_bank #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 7,
  parameter int TAG_W  = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  reservation_station_bank_if.slave rs_io
);
  localparam int c_num_rs  = 6;
  localparam int c_num_cls = 3;

  logic [c_num_rs-1:0] busy_q, busy_d, issued_q, issued_d, age_q, age_d;
  logic [OPC_W-1:0]    opc_q [c_num_rs];
  logic [OPC_W-1:0]    opc_d [c_num_rs];
  logic [TAG_W-1:0]    qj_q  [c_num_rs];
  logic [TAG_W-1:0]    qj_d  [c_num_rs];
  logic [TAG_W-1:0]    qk_q  [c_num_rs];
  logic [TAG_W-1:0]    qk_d  [c_num_rs];
  logic [DATA_W-1:0]   vj_q  [c_num_rs];
  logic [DATA_W-1:0]   vj_d  [c_num_rs];
  logic [DATA_W-1:0]   vk_q  [c_num_rs];
  logic [DATA_W-1:0]   vk_d  [c_num_rs];
  logic [DATA_W-1:0]   imm_q [c_num_rs];
  logic [DATA_W-1:0]   imm_d [c_num_rs];
  logic                disp_err_q, disp_err_d;

  logic [c_num_rs-1:0]  w_ready;
  logic [c_num_cls-1:0] w_iss_valid, w_fu_ready;
  logic [2:0]           w_iss_sel [c_num_cls];
  logic [TAG_W-1:0]     w_iss_tag [c_num_cls];
  logic [OPC_W-1:0]     w_iss_opc [c_num_cls];
  logic [DATA_W-1:0]    w_iss_vj  [c_num_cls];
  logic [DATA_W-1:0]    w_iss_vk  [c_num_cls];
  logic [DATA_W-1:0]    w_iss_imm [c_num_cls];
  logic                 w_flush, w_disp_ok, w_cdb_hit, w_cap_j, w_cap_k;
  logic [2:0]           w_slot;

`ifdef RS_FLUSH_EN
  assign w_flush = rs_io.flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_slot    = 3'(rs_io.disp_rs - TAG_W'(1));
  assign w_cdb_hit = rs_io.cdb_valid && (rs_io.cdb_tag != '0);
  assign w_cap_j   = w_cdb_hit && (rs_io.disp_qj == rs_io.cdb_tag);
  assign w_cap_k   = w_cdb_hit && (rs_io.disp_qk == rs_io.cdb_tag);
  // A slot freed by the CDB this cycle still reads busy, so its dispatch drops.
  assign w_disp_ok = rs_io.disp_valid && !w_flush &&
                     (rs_io.disp_rs >= TAG_W'(1)) && (rs_io.disp_rs <= TAG_W'(c_num_rs)) &&
                     !busy_q[w_slot];

  always_comb begin
    for (int i = 0; i < c_num_rs; i++) begin
      w_ready[i] = busy_q[i] && !issued_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
  end

  for (genvar c = 0; c < c_num_cls; c++) begin : g_class
    localparam int c_lo = 2 * c;
    localparam int c_hi = 2 * c + 1;
    logic w_pick_hi;
    // Upper slot wins only when it is strictly older; equal age goes low.
    assign w_pick_hi      = w_ready[c_hi] && (!w_ready[c_lo] || (age_q[c_hi] && !age_q[c_lo]));
    assign w_iss_valid[c] = w_ready[c_lo] || w_ready[c_hi];
    assign w_iss_sel[c]   = w_pick_hi ? 3'(c_hi) : 3'(c_lo);
    assign w_iss_tag[c]   = w_iss_valid[c] ? TAG_W'(w_iss_sel[c]) + TAG_W'(1) : '0;
    assign w_iss_opc[c]   = w_iss_valid[c] ? opc_q[w_iss_sel[c]] : '0;
    assign w_iss_vj[c]    = w_iss_valid[c] ? vj_q[w_iss_sel[c]]  : '0;
    assign w_iss_vk[c]    = w_iss_valid[c] ? vk_q[w_iss_sel[c]]  : '0;
    assign w_iss_imm[c]   = w_iss_valid[c] ? imm_q[w_iss_sel[c]] : '0;
  end

  assign w_fu_ready = {rs_io.alu_ready, rs_io.ld_ready, rs_io.st_ready};

  always_comb begin
    busy_d   = busy_q;
    issued_d = issued_q;
    age_d    = age_q;
    opc_d    = opc_q;
    qj_d     = qj_q;
    qk_d     = qk_q;
    vj_d     = vj_q;
    vk_d     = vk_q;
    imm_d    = imm_q;

    for (int c = 0; c < c_num_cls; c++) begin
      if (w_iss_valid[c] && w_fu_ready[c]) issued_d[w_iss_sel[c]] = 1'b1;
    end

    for (int i = 0; i < c_num_rs; i++) begin
      if (busy_q[i] && w_cdb_hit && (qj_q[i] == rs_io.cdb_tag)) begin
        qj_d[i] = '0;
        vj_d[i] = rs_io.cdb_data;
      end
      if (busy_q[i] && w_cdb_hit && (qk_q[i] == rs_io.cdb_tag)) begin
        qk_d[i] = '0;
        vk_d[i] = rs_io.cdb_data;
      end
      if (rs_io.cdb_valid && (rs_io.cdb_tag == TAG_W'(i + 1))) begin
        busy_d[i]   = 1'b0;
        issued_d[i] = 1'b0;
      end
    end

    if (w_disp_ok) begin
      busy_d[w_slot]   = 1'b1;
      issued_d[w_slot] = 1'b0;
      opc_d[w_slot]    = rs_io.disp_opcode;
      imm_d[w_slot]    = rs_io.disp_imm;
      qj_d[w_slot]     = w_cap_j ? '0 : rs_io.disp_qj;
      vj_d[w_slot]     = w_cap_j ? rs_io.cdb_data : rs_io.disp_vj;
      qk_d[w_slot]     = w_cap_k ? '0 : rs_io.disp_qk;
      vk_d[w_slot]     = w_cap_k ? rs_io.cdb_data : rs_io.disp_vk;
      // The surviving partner, if any, becomes the older of the pair.
      if (busy_d[w_slot ^ 3'd1]) begin
        age_d[w_slot]         = 1'b0;
        age_d[w_slot ^ 3'd1]  = 1'b1;
      end else begin
        age_d[w_slot] = 1'b1;
      end
    end

    if (w_flush) begin
      busy_d   = '0;
      issued_d = '0;
    end

    disp_err_d = rs_io.disp_valid && !w_disp_ok && !w_flush;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q     <= '0;
      issued_q   <= '0;
      age_q      <= '0;
      disp_err_q <= 1'b0;
      opc_q      <= '{default: '0};
      qj_q       <= '{default: '0};
      qk_q       <= '{default: '0};
      vj_q       <= '{default: '0};
      vk_q       <= '{default: '0};
      imm_q      <= '{default: '0};
    end else begin
      busy_q     <= busy_d;
      issued_q   <= issued_d;
      age_q      <= age_d;
      disp_err_q <= disp_err_d;
      opc_q      <= opc_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
      imm_q      <= imm_d;
    end
  end

  assign rs_io.rs_busy   = busy_q;
  assign rs_io.disp_err  = disp_err_q;

  assign rs_io.st_valid  = w_iss_valid[0];
  assign rs_io.st_tag    = w_iss_tag[0];
  assign rs_io.st_opc    = w_iss_opc[0];
  assign rs_io.st_vj     = w_iss_vj[0];
  assign rs_io.st_vk     = w_iss_vk[0];
  assign rs_io.st_imm    = w_iss_imm[0];

  assign rs_io.ld_valid  = w_iss_valid[1];
  assign rs_io.ld_tag    = w_iss_tag[1];
  assign rs_io.ld_opc    = w_iss_opc[1];
  assign rs_io.ld_vj     = w_iss_vj[1];
  assign rs_io.ld_vk     = w_iss_vk[1];
  assign rs_io.ld_imm    = w_iss_imm[1];

  assign rs_io.alu_valid = w_iss_valid[2];
  assign rs_io.alu_tag   = w_iss_tag[2];
  assign rs_io.alu_opc   = w_iss_opc[2];
  assign rs_io.alu_vj    = w_iss_vj[2];
  assign rs_io.alu_vk    = w_iss_vk[2];
  assign rs_io.alu_imm   = w_iss_imm[2];
endmodule
`default_nettype wire
